// File: rtl/bin2bcd_display_feed.sv
// Serial double-dabble converter feeding the seven-segment driver.
// Self-triggers whenever the input differs from the last converted value.
module bin2bcd_display_feed #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                CLK_in,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    Value,
  output logic [4*DIGITS-1:0] Bcd,
  output logic [DIGITS-1:0]   Digit_en,
  output logic                Busy,
  output logic                Done
);

  localparam int SW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [WIDTH-1:0]  last_value;
  logic [WIDTH-1:0]  bin;
  logic [SW-1:0]     scratch;
  logic [SW-1:0]     adj;
  logic [CW-1:0]     count;
  logic [DIGITS-1:0] en_d;
  logic              start;
  logic              last_shift;
  logic              seen;

  assign start      = (Value != last_value);
  assign last_shift = (count == CW'(WIDTH - 1));
  assign Busy       = (state_q != IDLE);

  always_comb begin
    adj = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Leading-zero mask: a digit shows if it or any higher digit is nonzero.
  always_comb begin
    en_d = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (scratch[4*i +: 4] != 4'd0);
      en_d[i] = seen;
    end
    en_d[0] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_in) begin
    if (Reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge CLK_in) begin
    if (Reset) begin
      last_value <= '0;
      bin        <= '0;
      scratch    <= '0;
      count      <= '0;
      Bcd        <= '0;
      Digit_en   <= DIGITS'(1);
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            bin        <= Value;
            last_value <= Value;
            scratch    <= '0;
            count      <= '0;
          end
        end
        SHIFT: begin
          // Top adjusted bit is always zero given enough digits.
          scratch <= SW'({adj, bin[WIDTH-1]});
          bin     <= bin << 1;
          count   <= count + 1'b1;
        end
        DONE: begin
          Bcd      <= scratch;
          Digit_en <= en_d;
          Done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_display_feed.sv
// Directed bench for bin2bcd_display_feed.
// Expected BCD and masks are hand-computed constants.
module tb_bin2bcd_display_feed;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [19:0] bcd;
  logic [4:0]  digit_en;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  int bad_cnt = 0;
  bit mon_on = 0;
  int c;
  int d0;
  int b0;

  bin2bcd_display_feed #(
    .WIDTH (16),
    .DIGITS(5)
  ) dut (
    .CLK_in  (clk),
    .Reset   (rst),
    .Value   (value),
    .Bcd     (bcd),
    .Digit_en(digit_en),
    .Busy    (busy),
    .Done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (mon_on && bcd != 20'h00000 && bcd != 20'h00100
        && bcd != 20'h00200)
      bad_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int max, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < max);
    chk("done_seen", done, 1);
  endtask

  initial begin
    rst   = 1'b1;
    value = '0;
    repeat (3) @(negedge clk);
    chk("rst_bcd", bcd, 20'h00000);
    chk("rst_en", digit_en, 5'b00001);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    rst = 1'b0;
    d0 = done_cnt;
    b0 = busy_cnt;
    repeat (40) @(negedge clk);
    chk("zero_bcd", bcd, 20'h00000);
    chk("zero_en", digit_en, 5'b00001);
    chk("zero_dones", done_cnt - d0, 0);
    chk("zero_busy", busy_cnt - b0, 0);

    value = 16'd1234;
    @(negedge clk);
    chk("t1234_busy", busy, 1);
    wait_done(40, c);
    chk("t1234_lat", c, 17);
    chk("t1234_bcd", bcd, 20'h01234);
    chk("t1234_en", digit_en, 5'b01111);
    @(negedge clk);
    chk("t1234_pulse", done, 0);
    chk("t1234_idle", busy, 0);

    value = 16'd65025;
    wait_done(40, c);
    chk("t65025_lat", c, 18);
    chk("t65025_bcd", bcd, 20'h65025);
    chk("t65025_en", digit_en, 5'b11111);
    value = 16'hFFFF;
    wait_done(40, c);
    chk("tffff_gap", c, 18);
    chk("tffff_bcd", bcd, 20'h65535);
    chk("tffff_en", digit_en, 5'b11111);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mon_on = 1'b1;
    value = 16'd100;
    repeat (6) @(negedge clk);
    value = 16'd200;
    wait_done(40, c);
    chk("t100_lat", c, 12);
    chk("t100_bcd", bcd, 20'h00100);
    chk("t100_en", digit_en, 5'b00111);
    wait_done(40, c);
    chk("t200_gap", c, 18);
    chk("t200_bcd", bcd, 20'h00200);
    chk("t200_en", digit_en, 5'b00111);
    @(negedge clk);
    mon_on = 1'b0;
    chk("t100_no_glitch", bad_cnt, 0);

    d0 = done_cnt;
    for (int i = 0; i < 100; i++) begin
      value = 16'd132;
      @(negedge clk);
    end
    chk("live_dones", done_cnt - d0, 1);
    chk("live_bcd", bcd, 20'h00132);
    chk("live_en", digit_en, 5'b00111);

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    value = 16'd9999;
    repeat (9) @(negedge clk);
    chk("t9999_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_bcd", bcd, 20'h00000);
    chk("abort_en", digit_en, 5'b00001);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    wait_done(40, c);
    chk("t9999_lat", c, 18);
    chk("t9999_bcd", bcd, 20'h09999);
    chk("t9999_en", digit_en, 5'b01111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
